// File: rtl/rega_multizona.sv
`default_nettype none
// ============================================================================
// Module      : rega_multizona
// Description : Multi-zone irrigation sequencer. Serves one zone at a time in
//               round-robin order (sprinkler or drip), enforces a fixed
//               watering turn and pause, and latches safety faults.
// Revision    : 1.0 - initial release
// ============================================================================
module rega_multizona #(
  parameter int N_ZONAS     = 4,
  parameter int TEMPO_REGA  = 8,
  parameter int TEMPO_PAUSA = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_ZONAS-1:0]         asp,
  input  logic [N_ZONAS-1:0]         got,
  input  logic [1:0]                 mef1,
  input  logic                       aduba,
  input  logic                       VE,
  input  logic                       critico,
  input  logic                       clr_erro,
  output logic [1:0]                 rega,
  output logic [$clog2(N_ZONAS)-1:0] zona,
  output logic                       ativo,
  output logic                       erro,
  output logic [2:0]                 cod_erro,
  output logic                       fim_zona
);

  localparam int ZW   = $clog2(N_ZONAS);
  localparam int TMAX = (TEMPO_REGA > TEMPO_PAUSA) ? TEMPO_REGA : TEMPO_PAUSA;
  localparam int CW   = $clog2(TMAX) + 1;

  localparam logic [1:0] MODO_ASP = 2'b10;
  localparam logic [1:0] MODO_GOT = 2'b01;
  localparam logic [1:0] MODO_OFF = 2'b00;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    VALIDA  = 3'd1,
    REGANDO = 3'd2,
    PAUSA   = 3'd3,
    ERRO    = 3'd4
  } estado_t;

  estado_t       estado_q;
  logic [ZW-1:0] ptr_q;
  logic [ZW-1:0] zona_q;
  logic [1:0]    modo_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    rega_q;
  logic          ativo_q;
  logic          erro_q;
  logic [2:0]    cod_erro_q;
  logic          fim_zona_q;

  logic          scan_hit;
  logic [ZW-1:0] scan_idx;
  logic [ZW-1:0] cand;
  logic [2:0]    err_cod;
  logic          pedido_caiu;

  // Round-robin search: the first requesting zone at or after ptr wins.
  // Iterating from the farthest offset down lets the nearest hit overwrite.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    cand     = '0;
    for (int i = N_ZONAS - 1; i >= 0; i--) begin
      cand = ZW'((int'(ptr_q) + i) % N_ZONAS);
      if (asp[cand] | got[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // Safety checks on the latched zone; lowest code has highest priority.
  always_comb begin
    err_cod = 3'd0;
    if (asp[zona_q] && got[zona_q])        err_cod = 3'd1;
    else if (mef1 != 2'b11)                err_cod = 3'd2;
    else if (aduba && modo_q == MODO_GOT)  err_cod = 3'd3;
    else if (VE)                           err_cod = 3'd4;
    else if (!critico)                     err_cod = 3'd5;
  end

  // The served zone no longer asks for the mode it was granted.
  always_comb begin
    pedido_caiu = (modo_q == MODO_ASP) ? !asp[zona_q] : !got[zona_q];
  end

  // Sequencer FSM with registered outputs; async reset forces outputs off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      ptr_q      <= '0;
      zona_q     <= '0;
      modo_q     <= MODO_OFF;
      cnt_q      <= '0;
      rega_q     <= MODO_OFF;
      ativo_q    <= 1'b0;
      erro_q     <= 1'b0;
      cod_erro_q <= 3'd0;
      fim_zona_q <= 1'b0;
    end else begin
      fim_zona_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (scan_hit) begin
            zona_q   <= scan_idx;
            modo_q   <= asp[scan_idx] ? MODO_ASP : MODO_GOT;
            estado_q <= VALIDA;
          end
        end
        VALIDA: begin
          if (err_cod != 3'd0) begin
            erro_q     <= 1'b1;
            cod_erro_q <= err_cod;
            estado_q   <= ERRO;
          end else begin
            cnt_q    <= CW'(TEMPO_REGA - 1);
            rega_q   <= modo_q;
            ativo_q  <= 1'b1;
            estado_q <= REGANDO;
          end
        end
        REGANDO: begin
          if (err_cod != 3'd0) begin
            rega_q     <= MODO_OFF;
            ativo_q    <= 1'b0;
            erro_q     <= 1'b1;
            cod_erro_q <= err_cod;
            estado_q   <= ERRO;
          end else if (pedido_caiu) begin
            rega_q   <= MODO_OFF;
            ativo_q  <= 1'b0;
            cnt_q    <= CW'(TEMPO_PAUSA - 1);
            estado_q <= PAUSA;
          end else if (cnt_q == '0) begin
            rega_q     <= MODO_OFF;
            ativo_q    <= 1'b0;
            fim_zona_q <= 1'b1;
            cnt_q      <= CW'(TEMPO_PAUSA - 1);
            estado_q   <= PAUSA;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PAUSA: begin
          if (cnt_q == '0) begin
            ptr_q    <= (zona_q == ZW'(N_ZONAS - 1)) ? '0 : zona_q + 1'b1;
            estado_q <= OCIOSO;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ERRO: begin
          rega_q  <= MODO_OFF;
          ativo_q <= 1'b0;
          if (clr_erro) begin
            erro_q     <= 1'b0;
            cod_erro_q <= 3'd0;
            estado_q   <= OCIOSO;
          end
        end
        default: begin
          rega_q   <= MODO_OFF;
          ativo_q  <= 1'b0;
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign rega     = rega_q;
  assign zona     = zona_q;
  assign ativo    = ativo_q;
  assign erro     = erro_q;
  assign cod_erro = cod_erro_q;
  assign fim_zona = fim_zona_q;

endmodule
`default_nettype wire

// File: tb/tb_rega_multizona.sv
`default_nettype none
// ============================================================================
// Module      : tb_rega_multizona
// Description : Directed self-checking bench for rega_multizona (defaults:
//               4 zones, 8 watering cycles, 2 pause cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rega_multizona;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] asp, got;
  logic [1:0] mef1;
  logic       aduba, VE, critico, clr_erro;
  logic [1:0] rega;
  logic [1:0] zona;
  logic       ativo, erro, fim_zona;
  logic [2:0] cod_erro;

  int checks = 0;
  int errors = 0;

  rega_multizona #(.N_ZONAS(4), .TEMPO_REGA(8), .TEMPO_PAUSA(2)) dut (
    .clk(clk), .reset(reset), .asp(asp), .got(got), .mef1(mef1),
    .aduba(aduba), .VE(VE), .critico(critico), .clr_erro(clr_erro),
    .rega(rega), .zona(zona), .ativo(ativo), .erro(erro),
    .cod_erro(cod_erro), .fim_zona(fim_zona)
  );

  always #5 clk = ~clk;

  // Compare all outputs as {rega, zona, ativo, erro, cod_erro, fim_zona}.
  task automatic chk(input string tag, input logic [1:0] r, input logic [1:0] z,
                     input logic a, input logic e, input logic [2:0] c,
                     input logic f);
    logic [9:0] obs, want;
    obs  = {rega, zona, ativo, erro, cod_erro, fim_zona};
    want = {r, z, a, e, c, f};
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; asp = '0; got = '0; mef1 = 2'b11;
    aduba = 1'b0; VE = 1'b0; critico = 1'b1; clr_erro = 1'b0;
    #3;
    chk("reset_values", 2'b00, 2'd0, 0, 0, 3'd0, 0);
    tick(1);
    reset = 1'b0;

    // Single sprinkler zone 2: one VALIDA cycle, 8 watering, pulse, 2 off
    asp = 4'b0100;
    tick(1);
    chk("z2_valida", 2'b00, 2'd2, 0, 0, 3'd0, 0);
    tick(1);
    chk("z2_rega_first", 2'b10, 2'd2, 1, 0, 3'd0, 0);
    tick(7);
    chk("z2_rega_8th", 2'b10, 2'd2, 1, 0, 3'd0, 0);
    tick(1);
    chk("z2_fim_pulse", 2'b00, 2'd2, 0, 0, 3'd0, 1);
    asp = 4'b0000;
    tick(1);
    chk("z2_pausa2", 2'b00, 2'd2, 0, 0, 3'd0, 0);

    // Round robin zone 0 (sprinkler) -> zone 3 (drip) -> wrap to zone 0
    tick(1);
    do_reset();
    asp = 4'b0001; got = 4'b1000;
    tick(1);
    chk("rr_z0_valida", 2'b00, 2'd0, 0, 0, 3'd0, 0);
    tick(1);
    chk("rr_z0_rega", 2'b10, 2'd0, 1, 0, 3'd0, 0);
    tick(8);
    chk("rr_z0_fim", 2'b00, 2'd0, 0, 0, 3'd0, 1);
    tick(3);
    chk("rr_z3_valida", 2'b00, 2'd3, 0, 0, 3'd0, 0);
    tick(1);
    chk("rr_z3_rega", 2'b01, 2'd3, 1, 0, 3'd0, 0);
    tick(8);
    chk("rr_z3_fim", 2'b00, 2'd3, 0, 0, 3'd0, 1);
    tick(3);
    chk("rr_wrap_z0_valida", 2'b00, 2'd0, 0, 0, 3'd0, 0);
    tick(1);
    chk("rr_wrap_z0_rega", 2'b10, 2'd0, 1, 0, 3'd0, 0);

    // Fertilisation during drip on zone 1 -> error 3, clear, resume
    asp = '0; got = '0;
    do_reset();
    got = 4'b0010;
    tick(2);
    chk("adub_rega1", 2'b01, 2'd1, 1, 0, 3'd0, 0);
    tick(3);
    aduba = 1'b1;
    tick(1);
    chk("adub_erro3", 2'b00, 2'd1, 0, 1, 3'd3, 0);
    aduba = 1'b0;
    tick(1);
    chk("adub_erro_hold", 2'b00, 2'd1, 0, 1, 3'd3, 0);
    clr_erro = 1'b1;
    tick(1);
    chk("adub_cleared", 2'b00, 2'd1, 0, 0, 3'd0, 0);
    clr_erro = 1'b0;
    tick(2);
    chk("adub_resume", 2'b01, 2'd1, 1, 0, 3'd0, 0);

    // Both requests on zone 0 and mef1 wrong: code 1 outranks code 2
    got = '0;
    do_reset();
    asp = 4'b0001; got = 4'b0001; mef1 = 2'b01;
    tick(2);
    chk("prio_cod1", 2'b00, 2'd0, 0, 1, 3'd1, 0);
    clr_erro = 1'b1;
    tick(1);
    chk("prio_clear", 2'b00, 2'd0, 0, 0, 3'd0, 0);
    clr_erro = 1'b0;
    tick(2);
    chk("prio_retrigger", 2'b00, 2'd0, 0, 1, 3'd1, 0);

    // Request drop on 3rd watering cycle -> pause without pulse
    asp = '0; got = '0; mef1 = 2'b11;
    do_reset();
    asp = 4'b0010;
    tick(4);
    chk("drop_rega3", 2'b10, 2'd1, 1, 0, 3'd0, 0);
    asp = 4'b0000;
    tick(1);
    chk("drop_pausa_nofim", 2'b00, 2'd1, 0, 0, 3'd0, 0);
    tick(1);
    chk("drop_pausa2_nofim", 2'b00, 2'd1, 0, 0, 3'd0, 0);
    tick(1);
    asp = 4'b0010;
    tick(2);
    chk("drop_rewater", 2'b10, 2'd1, 1, 0, 3'd0, 0);

    // Asynchronous reset mid-watering, checked before any clock edge
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 2'b00, 2'd0, 0, 0, 3'd0, 0);
    reset = 1'b0;
    asp = '0;

    // Critical-low water level during watering -> error 5
    tick(1);
    got = 4'b0001;
    tick(2);
    critico = 1'b0;
    tick(1);
    chk("critico_cod5", 2'b00, 2'd0, 0, 1, 3'd5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
